// File: rtl/swervolf_ram_init_ctrl_if.sv
// AXI4 write-channel bundle (AW/W/B) between the RAM init sequencer and the RAM.
// The read channels and the tied-off awid/awsize/awburst are handled at the top level.
interface swervolf_ram_init_ctrl_if;
  logic [31:0] o_awaddr;
  logic [7:0]  o_awlen;
  logic        o_awvalid;
  logic        i_awready;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb;
  logic        o_wlast;
  logic        o_wvalid;
  logic        i_wready;
  logic [1:0]  i_bresp;
  logic        i_bvalid;
  logic        o_bready;

  // Sequencer side: issues bursts and accepts responses.
  modport master (
    output o_awaddr, o_awlen, o_awvalid,
    input  i_awready,
    output o_wdata, o_wstrb, o_wlast, o_wvalid,
    input  i_wready,
    input  i_bresp, i_bvalid,
    output o_bready
  );

  // RAM side: accepts bursts and returns responses.
  modport slave (
    input  o_awaddr, o_awlen, o_awvalid,
    output i_awready,
    input  o_wdata, o_wstrb, o_wlast, o_wvalid,
    output i_wready,
    output i_bresp, i_bvalid,
    input  o_bready
  );
endinterface

// File: rtl/swervolf_ram_init_ctrl.sv
// Main-RAM initialisation sequencer: write-only AXI4 master that fills
// [BASE_ADDR, BASE_ADDR+MEM_SIZE) with INCR bursts of BURST_LEN 8-byte beats,
// then reports done (and error on any non-OKAY response) to the core.
// Optional feature macro: RAM_INIT_PATTERN_EN -- when defined each beat carries
// {~beat_addr, beat_addr} instead of FILL_WORD.
module swervolf_ram_init_ctrl #(
  parameter logic [31:0] MEM_SIZE  = 32'h0001_0000,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned BURST_LEN = 16,
  parameter logic [63:0] FILL_WORD = 64'h0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  swervolf_ram_init_ctrl_if.master       bus,
  output logic                           o_init_done,
  output logic                           o_init_error
);

  localparam int unsigned BEAT_BYTES = 8;
  localparam logic [31:0] STEP       = 32'(BURST_LEN * BEAT_BYTES);
  localparam logic [31:0] END_ADDR   = BASE_ADDR + MEM_SIZE;
  localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        wvalid;
  logic        wlast;
  logic        bready;
  logic        done;
  logic        error;
  logic [7:0]  cnt;

`ifdef RAM_INIT_PATTERN_EN
  logic [63:0] wdata;
  logic [31:0] next_beat_addr;

  // Byte address of the following beat; low half of wdata holds the current one.
  assign next_beat_addr = wdata[31:0] + 32'(BEAT_BYTES);
  assign bus.o_wdata    = wdata;
`else
  assign bus.o_wdata    = FILL_WORD;
`endif

  assign bus.o_awaddr  = awaddr;
  assign bus.o_awlen   = LAST_BEAT;
  assign bus.o_awvalid = awvalid;
  assign bus.o_wstrb   = 8'hFF;
  assign bus.o_wlast   = wlast;
  assign bus.o_wvalid  = wvalid;
  assign bus.o_bready  = bready;
  assign o_init_done   = done;
  assign o_init_error  = error;

  // Fill sequencer: one AW, BURST_LEN W beats, one B per burst; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      awaddr  <= BASE_ADDR;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      wlast   <= 1'b0;
      bready  <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      cnt     <= 8'd0;
`ifdef RAM_INIT_PATTERN_EN
      wdata   <= 64'd0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            awaddr  <= BASE_ADDR;
            awvalid <= 1'b1;
            state   <= S_AW;
          end
        end

        S_AW: begin
          if (bus.i_awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            cnt     <= 8'd0;
            wlast   <= (LAST_BEAT == 8'd0);
`ifdef RAM_INIT_PATTERN_EN
            wdata   <= {~awaddr, awaddr};
`endif
            state   <= S_W;
          end
        end

        S_W: begin
          if (bus.i_wready) begin
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= S_B;
            end else begin
              cnt   <= cnt + 8'd1;
              wlast <= ((cnt + 8'd1) == LAST_BEAT);
`ifdef RAM_INIT_PATTERN_EN
              wdata <= {~next_beat_addr, next_beat_addr};
`endif
            end
          end
        end

        S_B: begin
          if (bus.i_bvalid) begin
            bready <= 1'b0;
            if (bus.i_bresp != 2'b00) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= S_ERR;
            end else if ((awaddr + STEP) == END_ADDR) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              awaddr  <= awaddr + STEP;
              awvalid <= 1'b1;
              state   <= S_AW;
            end
          end
        end

        S_DONE, S_ERR: begin
          if (i_start) begin
            done    <= 1'b0;
            error   <= 1'b0;
            awaddr  <= BASE_ADDR;
            awvalid <= 1'b1;
            state   <= S_AW;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swervolf_ram_init_ctrl.sv
// Bench for swervolf_ram_init_ctrl: randomly stalling AXI slave with a
// memory-array reference model, directed pass sequence in one initial block.
module tb_swervolf_ram_init_ctrl;

  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] MEM    = 32'h0000_0800;
  localparam int unsigned BL     = 4;
  localparam logic [63:0] FILL   = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [31:0] STEP   = 32'(BL * 8);
  localparam int          BURSTS = int'(MEM / STEP);
  localparam int          BEATS  = int'(MEM / 32'd8);
  localparam int          BOUND  = 20000;

  logic clk = 1'b0;
  logic rst;
  logic i_start;
  logic done;
  logic error;

  swervolf_ram_init_ctrl_if bus ();

  swervolf_ram_init_ctrl #(
    .MEM_SIZE (MEM),
    .BASE_ADDR(BASE),
    .BURST_LEN(BL),
    .FILL_WORD(FILL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .bus         (bus.master),
    .o_init_done (done),
    .o_init_error(error)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc++;

  // Slave / reference model state
  bit  stall = 1'b0;
  bit  spur  = 1'b0;
  int  err_burst = -1;
  int  n_aw, n_wburst, beat_idx, n_beats, n_b, done_rises;
  bit  b_pending, b_hold, last_hs;
  bit  p_aw_stall, p_w_stall;
  logic [31:0] p_awaddr;
  logic [63:0] p_wdata;
  logic        p_wlast;
  logic        p_done;
  logic [31:0] waddr;
  logic [63:0] mem [int unsigned];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [31:0] a);
`ifdef RAM_INIT_PATTERN_EN
    return {~a, a};
`else
    return FILL;
`endif
  endfunction

  function automatic logic rnd_ready();
    return stall ? 1'($urandom_range(0, 9) < 6) : 1'b1;
  endfunction

  // AXI slave: decides ready/valid at the falling edge (handshake lands on the next
  // rising edge), records beats into mem and checks protocol against the model.
  always @(negedge clk) begin
    if (rst) begin
      bus.i_awready = 1'b0;
      bus.i_wready  = 1'b0;
      bus.i_bvalid  = 1'b0;
      bus.i_bresp   = 2'b00;
      b_pending     = 1'b0;
      b_hold        = 1'b0;
      p_aw_stall    = 1'b0;
      p_w_stall     = 1'b0;
      p_done        = 1'b0;
    end else begin
      if (done && !p_done) done_rises++;

      if (p_aw_stall) begin
        chk("aw_valid_held", 64'(bus.o_awvalid), 64'(1));
        chk("aw_addr_stable", 64'(bus.o_awaddr), 64'(p_awaddr));
      end
      if (p_w_stall) begin
        chk("w_valid_held", 64'(bus.o_wvalid), 64'(1));
        chk("w_data_stable", bus.o_wdata, p_wdata);
        chk("w_last_stable", 64'(bus.o_wlast), 64'(p_wlast));
      end

      bus.i_awready = rnd_ready();
      if (bus.o_awvalid && bus.i_awready) begin
        chk("aw_addr", 64'(bus.o_awaddr), 64'(BASE + 32'(n_aw) * STEP));
        chk("aw_len", 64'(bus.o_awlen), 64'(BL - 1));
        chk("aw_no_extra", 64'(n_aw < BURSTS), 64'(1));
        n_aw++;
      end
      p_aw_stall = bus.o_awvalid && !bus.i_awready;
      p_awaddr   = bus.o_awaddr;

      bus.i_wready = rnd_ready();
      last_hs = 1'b0;
      if (bus.o_wvalid && bus.i_wready) begin
        waddr = BASE + 32'(n_wburst) * STEP + 32'(beat_idx) * 32'd8;
        chk("w_after_aw", 64'(n_aw > n_wburst), 64'(1));
        chk("w_data", bus.o_wdata, exp_data(waddr));
        chk("w_last", 64'(bus.o_wlast), 64'(beat_idx == int'(BL) - 1));
        chk("w_strb", 64'(bus.o_wstrb), 64'(8'hFF));
        mem[waddr] = bus.o_wdata;
        n_beats++;
        if (beat_idx == int'(BL) - 1) begin
          beat_idx = 0;
          n_wburst++;
          last_hs = 1'b1;
        end else begin
          beat_idx++;
        end
      end
      p_w_stall = bus.o_wvalid && !bus.i_wready;
      p_wdata   = bus.o_wdata;
      p_wlast   = bus.o_wlast;

      if (bus.o_bready) chk("bready_only_after_wlast", 64'(b_pending), 64'(1));
      if (b_pending) begin
        if (!b_hold) bus.i_bvalid = rnd_ready();
        b_hold      = bus.i_bvalid;
        bus.i_bresp = (n_b == err_burst) ? 2'b10 : 2'b00;
        if (bus.i_bvalid && bus.o_bready) begin
          n_b++;
          b_pending = 1'b0;
          b_hold    = 1'b0;
        end
      end else begin
        bus.i_bvalid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.i_bresp  = spur ? 2'($urandom_range(0, 3)) : 2'b00;
      end
      if (last_hs) b_pending = 1'b1;
      p_done = done;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic clear_model();
    n_aw = 0; n_wburst = 0; beat_idx = 0; n_beats = 0; n_b = 0; done_rises = 0;
    mem.delete();
  endtask

  // Waits for done, optionally throwing ignored i_start pulses at the busy DUT.
  task automatic wait_done(input bit pulses);
    int n = 0;
    while (!done && n < BOUND) begin
      i_start = pulses && (n % 37 == 5);
      step();
      n++;
    end
    i_start = 1'b0;
    chk("done_within_bound", 64'(done), 64'(1));
  endtask

  task automatic check_mem();
    logic [31:0] a;
    logic [63:0] v;
    chk("mem_word_count", 64'(mem.num()), 64'(BEATS));
    for (int i = 0; i < BEATS; i++) begin
      a = BASE + 32'(i) * 32'd8;
      v = 'x;
      if (mem.exists(a)) v = mem[a];
      chk("mem_word", v, exp_data(a));
    end
  endtask

  task automatic check_full_pass(input string tag);
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_error"}, 64'(error), 64'(0));
    chk({tag, "_aw_count"}, 64'(n_aw), 64'(BURSTS));
    chk({tag, "_b_count"}, 64'(n_b), 64'(BURSTS));
    chk({tag, "_beat_count"}, 64'(n_beats), 64'(BEATS));
    chk({tag, "_done_rises"}, 64'(done_rises), 64'(1));
    check_mem();
  endtask

  initial begin
    int t0;
    int n;
    rst = 1'b1;
    i_start = 1'b0;
    bus.i_awready = 1'b0;
    bus.i_wready  = 1'b0;
    bus.i_bvalid  = 1'b0;
    bus.i_bresp   = 2'b00;
    clear_model();
    repeat (3) step();

    // Reset state
    chk("rst_awvalid", 64'(bus.o_awvalid), 64'(0));
    chk("rst_wvalid", 64'(bus.o_wvalid), 64'(0));
    chk("rst_wlast", 64'(bus.o_wlast), 64'(0));
    chk("rst_bready", 64'(bus.o_bready), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_awaddr", 64'(bus.o_awaddr), 64'(BASE));
    rst = 1'b0;
    repeat (9) step();

    // Pass A: always-ready slave, exact minimum latency
    stall = 1'b0; spur = 1'b0;
    clear_model();
    t0 = cyc;
    pulse_start();
    wait_done(1'b0);
    chk("passA_cycles", 64'(cyc - t0), 64'(1 + BURSTS * (int'(BL) + 2)));
    check_full_pass("passA");
`ifdef RAM_INIT_PATTERN_EN
    chk("pattern_word_0x108", mem[32'h108], 64'hFFFF_FEF7_0000_0108);
`endif
    repeat (10) step();
    chk("passA_done_sticky", 64'(done), 64'(1));
    chk("passA_idle_awvalid", 64'(bus.o_awvalid), 64'(0));
    chk("passA_no_more_aw", 64'(n_aw), 64'(BURSTS));

    // Pass B: restart from DONE, random stalls, spurious B, ignored mid-pass starts
    stall = 1'b1; spur = 1'b1;
    clear_model();
    pulse_start();
    chk("passB_done_cleared", 64'(done), 64'(0));
    wait_done(1'b1);
    check_full_pass("passB");

    // Pass C: error response on the third burst
    clear_model();
    err_burst = 2;
    pulse_start();
    wait_done(1'b0);
    chk("passC_error", 64'(error), 64'(1));
    chk("passC_done", 64'(done), 64'(1));
    chk("passC_aw_count", 64'(n_aw), 64'(3));
    chk("passC_beat_count", 64'(n_beats), 64'(3 * int'(BL)));
    repeat (30) step();
    chk("passC_no_4th_aw", 64'(n_aw), 64'(3));
    chk("passC_awvalid_low", 64'(bus.o_awvalid), 64'(0));
    chk("passC_error_sticky", 64'(error), 64'(1));
    chk("passC_done_sticky", 64'(done), 64'(1));

    // Pass D: reset in the middle of the W phase, then a clean full pass
    err_burst = -1;
    clear_model();
    pulse_start();
    chk("passD_error_cleared", 64'(error), 64'(0));
    n = 0;
    while (n_beats < 5 && n < BOUND) begin
      step();
      n++;
    end
    chk("passD_reached_beat5", 64'(n_beats >= 5), 64'(1));
    rst = 1'b1;
    step();
    chk("midrst_awvalid", 64'(bus.o_awvalid), 64'(0));
    chk("midrst_wvalid", 64'(bus.o_wvalid), 64'(0));
    chk("midrst_wlast", 64'(bus.o_wlast), 64'(0));
    chk("midrst_bready", 64'(bus.o_bready), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_awaddr", 64'(bus.o_awaddr), 64'(BASE));
    step();
    rst = 1'b0;
    clear_model();
    step();
    pulse_start();
    wait_done(1'b0);
    check_full_pass("passD");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
